i2c_txn_scheduler: RTL

- Shares one I2C master among NREQ requesters and sequences complete multi-byte transactions on it.
- Arbitration is round-robin.
- Drives the master's command pins (start/stop/rd_wr/address/din), streams write bytes from the granted requester, returns read bytes, and reports NACK/timeout errors.
- Sits between client blocks (sensor pollers, config loaders) and the i2c_master instance.

---
 rtl/i2c_txn_scheduler.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_txn_scheduler.sv
// Round-robin scheduler that shares one I2C master among NREQ requesters and
// sequences start / address / data bytes / stop for each granted transaction.
module i2c_txn_scheduler #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned LW   = 4,
    parameter int unsigned TOUT = 1023
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req_i,
    input  logic [7*NREQ-1:0]   req_addr_i,
    input  logic [NREQ-1:0]     req_rd_wr_i,
    input  logic [LW*NREQ-1:0]  req_len_i,
    input  logic [8*NREQ-1:0]   req_wdata_i,
    output logic [NREQ-1:0]     gnt_o,
    output logic [NREQ-1:0]     wdata_pop_o,
    output logic [7:0]          rdata_o,
    output logic                rdata_valid_o,
    output logic [NREQ-1:0]     done_o,
    output logic                err_nack_o,
    output logic                err_tout_o,
    output logic                m_start_o,
    output logic                m_stop_o,
    output logic                m_rd_wr_o,
    output logic [6:0]          m_address_o,
    output logic [7:0]          m_din_o,
    input  logic [7:0]          m_dout_i,
    input  logic                m_byte_done_i,
    input  logic                m_ack_i,
    input  logic                m_idle_i
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TW = $clog2(TOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_ADDR  = 3'd2,
        S_XFER  = 3'd3,
        S_STOP  = 3'd4
    } state_e;

    state_e          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [LW-1:0]   rem_q, rem_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            cap_q, cap_d;
    logic [NREQ-1:0] pop_q, pop_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            rv_q, rv_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            err_nack_q, err_nack_d;
    logic            err_tout_q, err_tout_d;
    logic            m_start_q, m_start_d;
    logic            m_stop_q, m_stop_d;
    logic            m_rd_wr_q, m_rd_wr_d;
    logic [6:0]      m_addr_q, m_addr_d;
    logic [7:0]      m_din_q, m_din_d;

    logic            found_c;
    logic [PW-1:0]   win_c;
    logic            tout_hit_c;

    // Round-robin search upward from the slot after the last grant.
    always_comb begin
        int idx;
        found_c = 1'b0;
        win_c   = ptr_q;
        idx     = 0;
        for (int i = 1; i <= int'(NREQ); i++) begin
            idx = (int'(ptr_q) + i) % int'(NREQ);
            if (!found_c && req_i[idx]) begin
                found_c = 1'b1;
                win_c   = PW'(idx);
            end
        end
    end

    assign tout_hit_c = (tcnt_q == TW'(TOUT));

    always_comb begin
        int sel;
        int cur;
        sel        = int'(win_c);
        cur        = int'(ptr_q);
        state_d    = state_q;
        ptr_d      = ptr_q;
        gnt_d      = gnt_q;
        rem_d      = rem_q;
        tcnt_d     = tcnt_q;
        cap_d      = |pop_q;
        pop_d      = '0;
        rdata_d    = rdata_q;
        rv_d       = 1'b0;
        done_d     = '0;
        err_nack_d = (done_q != '0) ? 1'b0 : err_nack_q;
        err_tout_d = (done_q != '0) ? 1'b0 : err_tout_q;
        m_start_d  = 1'b0;
        m_stop_d   = m_stop_q;
        m_rd_wr_d  = m_rd_wr_q;
        m_addr_d   = m_addr_q;
        // Requester presents its next byte the cycle after a pop; take it then.
        m_din_d    = cap_q ? req_wdata_i[cur*8 +: 8] : m_din_q;

        case (state_q)
            S_IDLE: begin
                if (m_idle_i && found_c) begin
                    state_d      = S_START;
                    ptr_d        = win_c;
                    gnt_d        = '0;
                    gnt_d[win_c] = 1'b1;
                    m_addr_d     = req_addr_i[sel*7 +: 7];
                    m_rd_wr_d    = req_rd_wr_i[sel];
                    rem_d        = req_len_i[sel*LW +: LW];
                    m_din_d      = req_wdata_i[sel*8 +: 8];
                    m_start_d    = 1'b1;
                    m_stop_d     = (req_len_i[sel*LW +: LW] == '0);
                end
            end
            S_START: begin
                tcnt_d  = '0;
                state_d = S_ADDR;
            end
            S_ADDR: begin
                tcnt_d = tcnt_q + TW'(1);
                if (m_byte_done_i) begin
                    tcnt_d = '0;
                    if (!m_ack_i) begin
                        err_nack_d = 1'b1;
                        m_stop_d   = 1'b1;
                        state_d    = S_STOP;
                    end else if (rem_q == '0) begin
                        state_d = S_STOP;
                    end else begin
                        state_d  = S_XFER;
                        pop_d    = m_rd_wr_q ? gnt_q : '0;
                        m_stop_d = (rem_q == LW'(1));
                    end
                end else if (tout_hit_c) begin
                    err_tout_d = 1'b1;
                    m_stop_d   = 1'b1;
                    state_d    = S_STOP;
                end
            end
            S_XFER: begin
                tcnt_d = tcnt_q + TW'(1);
                if (m_byte_done_i) begin
                    tcnt_d = '0;
                    if (m_rd_wr_q && !m_ack_i) begin
                        err_nack_d = 1'b1;
                        m_stop_d   = 1'b1;
                        state_d    = S_STOP;
                    end else begin
                        rem_d    = rem_q - LW'(1);
                        m_stop_d = (rem_q <= LW'(2));
                        if (m_rd_wr_q) begin
                            pop_d = (rem_q > LW'(1)) ? gnt_q : '0;
                        end else begin
                            rdata_d = m_dout_i;
                            rv_d    = 1'b1;
                        end
                        if (rem_q == LW'(1)) begin
                            state_d = S_STOP;
                        end
                    end
                end else if (tout_hit_c) begin
                    err_tout_d = 1'b1;
                    m_stop_d   = 1'b1;
                    state_d    = S_STOP;
                end
            end
            S_STOP: begin
                if (m_idle_i) begin
                    done_d   = gnt_q;
                    gnt_d    = '0;
                    m_stop_d = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ptr_q      <= PW'(NREQ - 1);
            gnt_q      <= '0;
            rem_q      <= '0;
            tcnt_q     <= '0;
            cap_q      <= 1'b0;
            pop_q      <= '0;
            rdata_q    <= '0;
            rv_q       <= 1'b0;
            done_q     <= '0;
            err_nack_q <= 1'b0;
            err_tout_q <= 1'b0;
            m_start_q  <= 1'b0;
            m_stop_q   <= 1'b0;
            m_rd_wr_q  <= 1'b0;
            m_addr_q   <= '0;
            m_din_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            gnt_q      <= gnt_d;
            rem_q      <= rem_d;
            tcnt_q     <= tcnt_d;
            cap_q      <= cap_d;
            pop_q      <= pop_d;
            rdata_q    <= rdata_d;
            rv_q       <= rv_d;
            done_q     <= done_d;
            err_nack_q <= err_nack_d;
            err_tout_q <= err_tout_d;
            m_start_q  <= m_start_d;
            m_stop_q   <= m_stop_d;
            m_rd_wr_q  <= m_rd_wr_d;
            m_addr_q   <= m_addr_d;
            m_din_q    <= m_din_d;
        end
    end

    assign gnt_o         = gnt_q;
    assign wdata_pop_o   = pop_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rv_q;
    assign done_o        = done_q;
    assign err_nack_o    = err_nack_q;
    assign err_tout_o    = err_tout_q;
    assign m_start_o     = m_start_q;
    assign m_stop_o      = m_stop_q;
    assign m_rd_wr_o     = m_rd_wr_q;
    assign m_address_o   = m_addr_q;
    assign m_din_o       = m_din_q;

endmodule
